// File: rtl/capture_engine.sv
// rtl/capture_engine.sv - multi-channel triggered capture buffer with pre/post-trigger readout
// Optional feature: CAP_TRIG_MATCH_EN adds a channel-0 value/mask trigger.
module capture_engine #(
   parameter int NUM_CH     = 16,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_W     = 6,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] din,
   input  logic                         arm,
   input  logic                         clear,
   input  logic                         trigger,
`ifdef CAP_TRIG_MATCH_EN
   input  logic [DATA_WIDTH-1:0]        trig_value,
   input  logic [DATA_WIDTH-1:0]        trig_mask,
`endif
   input  logic [ADDR_W-1:0]            post_count,
   input  logic                         rd_en,
   input  logic [CH_W-1:0]              rd_ch,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic [1:0]                   state,
   output logic                         done,
   output logic [ADDR_W:0]              sample_count,
   output logic [ADDR_W-1:0]            trig_index
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRIG  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            wr_ptr;
   logic [ADDR_W:0]              count_q;
   logic [ADDR_W-1:0]            trig_addr;
   logic [ADDR_W-1:0]            post_left;
   logic                         wr_en;
   logic                         fire;
   logic                         start;
   logic                         trig_eff;
   logic [ADDR_W-1:0]            oldest;
   logic [ADDR_W-1:0]            rd_phys;
   logic [NUM_CH*DATA_WIDTH-1:0] rd_row;
   logic [DATA_WIDTH-1:0]        rd_sel;
   logic                         rd_ok;

   logic [NUM_CH*DATA_WIDTH-1:0] mem [DEPTH];

`ifdef CAP_TRIG_MATCH_EN
   logic match;
   assign match    = (((din[DATA_WIDTH-1:0] ^ trig_value) & trig_mask) == '0) && (trig_mask != '0);
   assign trig_eff = trigger | match;
`else
   assign trig_eff = trigger;
`endif

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      fire    = 1'b0;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_d = S_ARMED;
               start   = 1'b1;
            end
         end
         S_ARMED: begin
            wr_en = 1'b1;
            if (trig_eff) begin
               fire    = 1'b1;
               state_d = (post_count == '0) ? S_DONE : S_TRIG;
            end
         end
         S_TRIG: begin
            wr_en = 1'b1;
            if (post_left == ADDR_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (arm) begin
               state_d = S_ARMED;
               start   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clear) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q   <= S_IDLE;
         wr_ptr    <= '0;
         count_q   <= '0;
         trig_addr <= '0;
         post_left <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            wr_ptr  <= '0;
            count_q <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count_q != FULL) count_q <= count_q + 1'b1;
         end
         // post_count is ADDR_W bits, so it can never exceed DEPTH-1
         if (fire) begin
            trig_addr <= wr_ptr;
            post_left <= post_count;
         end else if (state_q == S_TRIG) begin
            post_left <= post_left - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Once wrapped, the next slot to be written holds the oldest sample
   assign oldest  = (count_q == FULL) ? wr_ptr : '0;
   assign rd_phys = oldest + rd_addr;
   assign rd_row  = mem[rd_phys];

   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch == CH_W'(k)) rd_sel = rd_row[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign rd_ok = (state_q == S_DONE) && ({1'b0, rd_addr} < count_q) && (32'(rd_ch) < NUM_CH);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         rd_data  <= (rd_en && rd_ok) ? rd_sel : '0;
      end
   end

   assign state        = state_q;
   assign done         = (state_q == S_DONE);
   assign sample_count = count_q;
   assign trig_index   = (state_q == S_DONE) ? (trig_addr - oldest) : '0;

endmodule

// File: tb/tb_capture_engine.sv
// tb/tb_capture_engine.sv - scoreboard bench for capture_engine (NUM_CH=2, DATA_WIDTH=8, ADDR_W=3)
module tb_capture_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        arm;
   logic        clear;
   logic        trigger;
`ifdef CAP_TRIG_MATCH_EN
   logic [7:0]  trig_value;
   logic [7:0]  trig_mask;
`endif
   logic [2:0]  post_count;
   logic        rd_en;
   logic [0:0]  rd_ch;
   logic [2:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [1:0]  state;
   logic        done;
   logic [3:0]  sample_count;
   logic [2:0]  trig_index;

   int vectors = 0;
   int errors  = 0;
   int done_n;
   logic [7:0] exp_q[$];
   string      name_q[$];

   always #5 clk = ~clk;

   capture_engine #(.NUM_CH(2), .DATA_WIDTH(8), .ADDR_W(3)) dut (
      .clk(clk), .rst(rst), .din(din), .arm(arm), .clear(clear), .trigger(trigger),
`ifdef CAP_TRIG_MATCH_EN
      .trig_value(trig_value), .trig_mask(trig_mask),
`endif
      .post_count(post_count), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .state(state), .done(done),
      .sample_count(sample_count), .trig_index(trig_index)
   );

   always @(negedge clk) begin
      if (rd_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rd_valid: got data %0h, required no response", rd_data);
         end else begin
            logic [7:0] e;
            string      nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL %s: got %0h, required %0h", nm, rd_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic rd(input string nm, input int ch, input int addr, input logic [7:0] e);
      rd_en   = 1'b1;
      rd_ch   = ch[0:0];
      rd_addr = addr[2:0];
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
   endtask

   task automatic rd_stop();
      rd_en = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_capture(input int tn, input int post, input bit trig_on_arm, output int dn);
      arm        = 1'b1;
      trigger    = trig_on_arm;
      din        = 16'hEEEE;
      post_count = post[2:0];
      tick();
      arm = 1'b0;
      dn  = -1;
      for (int n = 0; n < 30; n++) begin
         din     = {8'(8'h80 + n), 8'(n)};
         trigger = (n == tn);
         tick();
         if (state == 2'd3) begin
            dn = n;
            break;
         end
      end
      trigger = 1'b0;
   endtask

   initial begin
      rst = 1'b1; din = '0; arm = 0; clear = 0; trigger = 0; post_count = '0;
      rd_en = 0; rd_ch = '0; rd_addr = '0;
`ifdef CAP_TRIG_MATCH_EN
      trig_value = '0; trig_mask = '0;
`endif
      tick();
      tick();
      check("rst_state", state, 0);
      check("rst_done", done, 0);
      check("rst_count", sample_count, 0);
      check("rst_trig_index", trig_index, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      tick();

      // wrapped capture: trigger at n=10, 3 post samples
      run_capture(10, 3, 1'b0, done_n);
      check("wrap_done_n", done_n, 13);
      check("wrap_done", done, 1);
      check("wrap_count", sample_count, 8);
      check("wrap_trig_index", trig_index, 4);
      for (int a = 0; a < 8; a++) rd("wrap_ch0", 0, a, 8'(6 + a));
      rd("wrap_ch1_a0", 1, 0, 8'h86);
      rd_stop();

      // re-arm from DONE; trigger on first sample, fill exactly
      run_capture(0, 7, 1'b0, done_n);
      check("full_done_n", done_n, 7);
      check("full_count", sample_count, 8);
      check("full_trig_index", trig_index, 0);
      for (int a = 0; a < 8; a++) rd("full_ch0", 0, a, 8'(a));
      rd_stop();

      run_capture(0, 0, 1'b0, done_n);
      check("post0_done_n", done_n, 0);
      check("post0_count", sample_count, 1);
      check("post0_trig_index", trig_index, 0);
      rd("post0_a0", 0, 0, 8'h00);
      rd("post0_a1_oob", 1, 1, 8'h00);
      rd_stop();

      // partial buffer, unwrapped
      run_capture(1, 2, 1'b0, done_n);
      check("part_done_n", done_n, 3);
      check("part_count", sample_count, 4);
      check("part_trig_index", trig_index, 1);
      for (int a = 0; a < 4; a++) rd("part_ch0", 0, a, 8'(a));
      rd("part_ch1_a3", 1, 3, 8'h83);
      rd("part_a5_oob", 0, 5, 8'h00);
      rd_stop();

      // trigger coincident with arm is ignored
      run_capture(2, 1, 1'b1, done_n);
      check("armtrig_done_n", done_n, 3);
      check("armtrig_trig_index", trig_index, 2);
      check("armtrig_count", sample_count, 4);
      rd("armtrig_ch0_a2", 0, 2, 8'h02);
      rd_stop();

      // clear during TRIG
      arm = 1'b1; post_count = 3'd5; tick();
      arm = 1'b0;
      for (int n = 0; n <= 12; n++) begin
         din     = {8'(8'h80 + n), 8'(n)};
         trigger = (n == 10);
         clear   = (n == 12);
         if (n == 12) check("clr_pre_state", state, 2);
         tick();
      end
      clear = 1'b0; trigger = 1'b0;
      check("clr_state", state, 0);
      check("clr_done", done, 0);
      check("clr_count", sample_count, 0);
      check("clr_trig_index", trig_index, 0);
      rd("clr_rd_zero", 0, 0, 8'h00);
      rd_stop();

`ifdef CAP_TRIG_MATCH_EN
      trig_value = 8'h05; trig_mask = 8'hFF;
      run_capture(99, 1, 1'b0, done_n);
      check("match_done_n", done_n, 6);
      check("match_trig_index", trig_index, 5);
      trig_mask = 8'h00;
`endif

      tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule

// File: doc/capture_engine.md
CAPTURE_ENGINE -- requirements
Module: capture_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of captured channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, bits per channel sample.
REQ-003 SHALL have parameter ADDR_W, default 6, buffer depth DEPTH = 2^ADDR_W samples per channel.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port din  input  NUM_CH*DATA_WIDTH  channel samples, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port arm  input  1  start capture pulse.
REQ-008 SHALL have port clear  input  1  abort/discard capture pulse.
REQ-009 SHALL have port trigger  input  1  external trigger.
REQ-010 SHALL have port post_count  input  ADDR_W  samples to record after trigger sample; latched at trigger.
REQ-011 SHALL have ports rd_en (input, 1), rd_ch (input, clog2(NUM_CH), min 1), rd_addr (input, ADDR_W): readout request, channel, logical index (0 = oldest sample).
REQ-012 SHALL have ports rd_data (output, DATA_WIDTH) and rd_valid (output, 1): readout response.
REQ-013 SHALL have outputs state (2; IDLE=0, ARMED=1, TRIG=2, DONE=3), done (1), sample_count (ADDR_W+1), trig_index (ADDR_W).

Function
REQ-014 IDLE: no writes; arm -> ARMED, write pointer and sample_count set to 0.
REQ-015 ARMED/TRIG: every cycle all channels written at write pointer; pointer increments mod DEPTH; sample_count increments, saturating at DEPTH.
REQ-016 ARMED: trigger high -> TRIG; sample written that cycle is the trigger sample; its physical address and min(post_count, DEPTH-1) are latched.
REQ-017 TRIG: after exactly the latched count of further samples written, -> DONE; count 0 -> DONE directly from ARMED the cycle after the trigger sample.
REQ-018 trigger ignored outside ARMED and on the cycle arm is accepted.
REQ-019 DONE: no writes; done=1; trig_index = trigger sample's logical index; oldest sample = write pointer once buffer has wrapped, else address 0.
REQ-020 arm in DONE re-arms as in REQ-014; arm in ARMED/TRIG ignored.
REQ-021 clear in any state -> IDLE next cycle, sample_count=0, done=0, trig_index=0; clear wins over simultaneous arm/trigger.
REQ-022 Read latency 1 cycle: rd_valid = rd_en registered; rd_data = sample at physical (oldest + rd_addr) mod DEPTH of channel rd_ch.
REQ-023 rd_data SHALL be 0 when not DONE at request, rd_addr >= sample_count, or rd_ch >= NUM_CH; rd_valid still follows rd_en.
REQ-024 Reads SHALL not alter capture state; rd_en every cycle SHALL be supported.

Reset
REQ-025 rst: state IDLE, done 0, sample_count 0, trig_index 0, rd_valid 0, rd_data 0, pointers 0; buffer contents undefined; rst mid-capture aborts as clear.

Configuration
REQ-026 Macro CAP_TRIG_MATCH_EN defined: adds inputs trig_value, trig_mask (DATA_WIDTH each); effective trigger = trigger OR (((ch0 din ^ trig_value) & trig_mask) == 0 AND trig_mask != 0), same cycle.
REQ-027 Macro undefined: ports absent; trigger input sole trigger source.

Verification (NUM_CH=2, DATA_WIDTH=8, ADDR_W=3; ch0 din = n, ch1 din = 0x80+n, n = nth ARMED/TRIG cycle from 0)
REQ-028 arm, trigger at n=10, post_count=3 -> DONE after n=13; sample_count=8, trig_index=4; ch0 rd_addr 0..7 -> 6..13; ch1 rd_addr 0 -> 0x86.
REQ-029 trigger at n=1, post_count=2 -> sample_count=4, trig_index=1; ch0 rd_addr 0..3 -> 0..3, rd_addr 5 -> 0.
REQ-030 trigger at n=0, post_count=7 -> samples 0..7, trig_index=0; trigger at n=0, post_count=0 -> sample_count=1, DONE next cycle.
REQ-031 clear at n=12 during TRIG -> state=0 next cycle, done=0, sample_count=0; rd_en then -> rd_valid=1, rd_data=0.
REQ-032 arm and trigger same cycle, trigger again at n=2, post_count=1 -> trig_index=2, sample_count=4.
REQ-033 CAP_TRIG_MATCH_EN, trig_value=0x05, trig_mask=0xFF, trigger held 0, post_count=1 -> DONE after n=6, trig_index=5.
